// File: rtl/firram_ring_if.sv
// firram_ring_if -- bus bundle for the multi-channel sample-history RAM.
//
// Groups the write handshake, the read-burst request and the tap output
// stream of firram_ring. CH_W must equal the ring's derived channel index
// width, which is max(1, clog2(CHANNELS)).
//
// Signals:
//   wr_valid / wr_ready   sample write handshake (accepted when both high)
//   wr_chan / wr_data     channel and sample of the write
//   rd_start / rd_chan    one-cycle burst request and the channel to read
//   rd_busy               sequencer active
//   q / q_valid / q_last  tap stream, newest sample first
//   q_chan                channel of the burst being output
//
// Modports: master drives requests (MAC controller / bench), slave is the ring.
interface firram_ring_if #(
  parameter int DATA_W = 36,
  parameter int CH_W   = 1
);

  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_chan;
  logic [DATA_W-1:0] wr_data;
  logic              rd_start;
  logic [CH_W-1:0]   rd_chan;
  logic              rd_busy;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              q_last;
  logic [CH_W-1:0]   q_chan;

  modport master (
    output wr_valid, wr_chan, wr_data, rd_start, rd_chan,
    input  wr_ready, rd_busy, q, q_valid, q_last, q_chan
  );

  modport slave (
    input  wr_valid, wr_chan, wr_data, rd_start, rd_chan,
    output wr_ready, rd_busy, q, q_valid, q_last, q_chan
  );

endinterface

// File: rtl/firram_ring.sv
// firram_ring -- multi-channel circular sample-history RAM with a tap sequencer.
//
// Every channel keeps its last DEPTH samples in a circular buffer. A read
// burst streams the newest NTAPS samples of one channel, newest first, with
// one tap per cycle. Slots that were never written since reset come out as
// zero instead of whatever the RAM happens to hold.
//
// Ports:
//   clock   single clock, rising edge
//   reset   asynchronous, active-high; empties all channels, aborts a burst
//   bus     firram_ring_if slave modport (write handshake, burst request,
//           tap stream)
//
// Parameters: DATA_W sample width, DEPTH words per channel (power of 2, >= 4),
// NTAPS taps per burst (1..DEPTH), CHANNELS (1..16).
module firram_ring #(
  parameter int DATA_W   = 36,
  parameter int DEPTH    = 128,
  parameter int NTAPS    = 128,
  parameter int CHANNELS = 1
) (
  input  logic          clock,
  input  logic          reset,
  firram_ring_if.slave  bus
);

  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW        = $clog2(DEPTH);
  localparam int MEM_WORDS = CHANNELS * DEPTH;
  localparam int MEM_AW    = $clog2(MEM_WORDS);

  localparam logic [CH_W:0]   NUM_CH = (CH_W + 1)'(CHANNELS);
  localparam logic [PW-1:0]   LAST_K = PW'(NTAPS - 1);
  localparam logic [PW:0]     FULL   = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wptr_q [CHANNELS];
  logic [PW-1:0]     wptr_d [CHANNELS];
  logic [PW:0]       fill_q [CHANNELS];
  logic [PW:0]       fill_d [CHANNELS];
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [PW-1:0]     basePtr_q, basePtr_d;
  logic [PW:0]       baseFill_q, baseFill_d;
  logic [PW-1:0]     k_q, k_d;
  logic              qValid_q, qValid_d;
  logic              qLast_q, qLast_d;
  logic              zero_q, zero_d;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] rdData_q;

  logic              wrReady;
  logic              wrChanOk;
  logic              rdChanOk;
  logic              wrAccept;
  logic              rdIssue;
  logic [PW-1:0]     rdPtr;
  logic [MEM_AW-1:0] wrAddr;
  logic [MEM_AW-1:0] rdAddr;

  // Channel-major word address {chan, ptr}; the cast drops the unused
  // channel bit when CHANNELS is 1.
  function automatic logic [MEM_AW-1:0] memAddr(input logic [CH_W-1:0] ch,
                                               input logic [PW-1:0] p);
    return MEM_AW'({ch, p});
  endfunction

  // Writes stall only for the channel being read, so each burst sees a
  // frozen snapshot of that channel while other channels keep streaming.
  assign wrReady  = !((state_q != IDLE) && (bus.wr_chan == chan_q));
  assign wrChanOk = ({1'b0, bus.wr_chan} < NUM_CH);
  assign rdChanOk = ({1'b0, bus.rd_chan} < NUM_CH);
  assign wrAccept = bus.wr_valid && wrReady && wrChanOk;

  // Tap k lives k+1 slots behind the latched write pointer.
  assign rdPtr  = basePtr_q - PW'(1) - k_q;
  assign wrAddr = memAddr(bus.wr_chan, wptr_q[bus.wr_chan]);
  assign rdAddr = memAddr(chan_q, rdPtr);

  // Next-state logic: write pointer/fill bookkeeping plus the burst
  // sequencer. The start latches post-write pointer and fill so a write
  // accepted in the same cycle becomes tap 0.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    chan_d     = chan_q;
    basePtr_d  = basePtr_q;
    baseFill_d = baseFill_q;
    k_d        = k_q;
    qValid_d   = 1'b0;
    qLast_d    = 1'b0;
    zero_d     = zero_q;
    rdIssue    = 1'b0;

    if (wrAccept) begin
      wptr_d[bus.wr_chan] = wptr_q[bus.wr_chan] + PW'(1);
      if (fill_q[bus.wr_chan] != FULL) begin
        fill_d[bus.wr_chan] = fill_q[bus.wr_chan] + (PW + 1)'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.rd_start && rdChanOk) begin
          chan_d     = bus.rd_chan;
          basePtr_d  = wptr_d[bus.rd_chan];
          baseFill_d = fill_d[bus.rd_chan];
          k_d        = '0;
          state_d    = READ;
        end
      end
      READ: begin
        rdIssue  = 1'b1;
        zero_d   = ({1'b0, k_q} >= baseFill_q);
        qValid_d = 1'b1;
        qLast_d  = (k_q == LAST_K);
        if (k_q == LAST_K) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + PW'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. zero_q resets high so q reads 0 out of reset without
  // having to reset the RAM output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < CHANNELS; i++) begin
        wptr_q[i] <= '0;
        fill_q[i] <= '0;
      end
      chan_q     <= '0;
      basePtr_q  <= '0;
      baseFill_q <= '0;
      k_q        <= '0;
      qValid_q   <= 1'b0;
      qLast_q    <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      chan_q     <= chan_d;
      basePtr_q  <= basePtr_d;
      baseFill_q <= baseFill_d;
      k_q        <= k_d;
      qValid_q   <= qValid_d;
      qLast_q    <= qLast_d;
      zero_q     <= zero_d;
    end
  end

  // Simple dual-port RAM, registered read port; contents are never reset.
  // The read register only loads on issued reads, so q holds between taps.
  always_ff @(posedge clock) begin
    if (wrAccept) begin
      mem[wrAddr] <= bus.wr_data;
    end
    if (rdIssue) begin
      rdData_q <= mem[rdAddr];
    end
  end

  assign bus.wr_ready = wrReady;
  assign bus.rd_busy  = (state_q != IDLE);
  assign bus.q        = zero_q ? '0 : rdData_q;
  assign bus.q_valid  = qValid_q;
  assign bus.q_last   = qLast_q;
  assign bus.q_chan   = chan_q;

endmodule

// File: tb/tb_firram_ring.sv
// tb_firram_ring -- self-checking bench for firram_ring.
//
// Small geometry (DEPTH=16, NTAPS=12, CHANNELS=3) so wrap-around, fill
// saturation, zero-fill and an out-of-range channel index all show up in
// short bursts. The reference keeps every accepted sample per channel in a
// queue; tap k of a burst is the k-th newest sample, or zero when the
// channel has fewer than k+1 samples since reset.
module tb_firram_ring;

  localparam int DATA_W   = 36;
  localparam int DEPTH    = 16;
  localparam int NTAPS    = 12;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [DATA_W-1:0] hist [CHANNELS][$];

  firram_ring_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  firram_ring #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NTAPS   (NTAPS),
    .CHANNELS(CHANNELS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // 100 MHz-style free-running clock.
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference tap: k-th newest sample of the channel, zero if not yet written.
  function automatic logic [DATA_W-1:0] expTap(input int ch, input int k);
    int n;
    n = hist[ch].size();
    if (k < n && k < DEPTH) return hist[ch][n-1-k];
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] randData();
    return DATA_W'({$urandom(), $urandom()});
  endfunction

  // Write one sample while the sequencer is idle.
  task automatic applyStimulus(input int ch, input logic [DATA_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_chan  = CH_W'(ch);
    bus.wr_data  = d;
    #1;
    checkOutput("wr_ready_idle", bus.wr_ready, 1);
    step();
    if (ch < CHANNELS) hist[ch].push_back(d);
    bus.wr_valid = 1'b0;
  endtask

  // Full burst on channel ch, checked tap by tap.
  // coWrite: a write to ch in the rd_start cycle (must become tap 0).
  // concurrent: writes alternating between channel 1 and ch every busy cycle.
  // poke: an extra rd_start mid-burst that must be ignored.
  task automatic runBurst(input int ch, input bit coWrite,
                          input logic [DATA_W-1:0] coData,
                          input bit concurrent, input bit poke);
    logic [DATA_W-1:0] exp [NTAPS];
    logic [DATA_W-1:0] wd;
    int                wc;
    bit                expReady;
    int                tap;

    bus.rd_start = 1'b1;
    bus.rd_chan  = CH_W'(ch);
    if (coWrite) begin
      bus.wr_valid = 1'b1;
      bus.wr_chan  = CH_W'(ch);
      bus.wr_data  = coData;
    end
    #1;
    if (coWrite) begin
      checkOutput("wr_ready_start", bus.wr_ready, 1);
      hist[ch].push_back(coData);
    end
    for (int k = 0; k < NTAPS; k++) exp[k] = expTap(ch, k);
    step();

    wc = 0;
    wd = '0;
    expReady = 1'b0;
    for (int c = 1; c <= NTAPS + 1; c++) begin
      bus.rd_start = poke && (c == 5);
      bus.rd_chan  = (poke && c == 5) ? CH_W'((ch + 1) % CHANNELS) : CH_W'(ch);
      if (concurrent) begin
        wc = (c % 2 == 1) ? 1 : ch;
        wd = randData();
        bus.wr_valid = 1'b1;
        bus.wr_chan  = CH_W'(wc);
        bus.wr_data  = wd;
      end else begin
        bus.wr_valid = 1'b0;
      end
      #1;
      checkOutput("rd_busy_burst", bus.rd_busy, 1);
      if (c == 1) begin
        checkOutput("q_valid_lead", bus.q_valid, 0);
      end else begin
        tap = c - 2;
        checkOutput("q_valid_tap", bus.q_valid, 1);
        checkOutput($sformatf("q_tap%0d", tap), bus.q, exp[tap]);
        checkOutput("q_last_tap", bus.q_last, (tap == NTAPS - 1) ? 1 : 0);
        checkOutput("q_chan_tap", bus.q_chan, ch);
      end
      if (concurrent) begin
        expReady = (wc != ch);
        checkOutput("wr_ready_busy", bus.wr_ready, expReady);
      end
      step();
      if (concurrent && expReady) hist[wc].push_back(wd);
    end

    bus.rd_start = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    checkOutput("rd_busy_end", bus.rd_busy, 0);
    checkOutput("q_valid_end", bus.q_valid, 0);
    checkOutput("q_last_end", bus.q_last, 0);
    checkOutput("q_hold_end", bus.q, exp[NTAPS-1]);
    step();
    checkOutput("q_valid_after", bus.q_valid, 0);
    checkOutput("rd_busy_after", bus.rd_busy, 0);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_chan  = '0;
    bus.wr_data  = '0;
    bus.rd_start = 1'b0;
    bus.rd_chan  = '0;

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    checkOutput("rst_rd_busy", bus.rd_busy, 0);
    checkOutput("rst_q_valid", bus.q_valid, 0);
    checkOutput("rst_q_last", bus.q_last, 0);
    checkOutput("rst_q", bus.q, 0);
    checkOutput("rst_q_chan", bus.q_chan, 0);
    checkOutput("rst_wr_ready", bus.wr_ready, 1);

    // Fresh channel: all zero taps.
    runBurst(0, 1'b0, '0, 1'b0, 1'b0);

    // Partial fill: five samples then zero-fill.
    for (int n = 0; n < 5; n++) applyStimulus(0, randData());
    runBurst(0, 1'b0, '0, 1'b0, 1'b0);

    // Wrap-around with saturated fill, plus an ignored mid-burst rd_start.
    for (int n = 0; n < 40; n++) applyStimulus(0, randData());
    runBurst(0, 1'b0, '0, 1'b0, 1'b1);

    // Interleaved channels, then read ch2 while writing ch1 and ch2.
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1, DATA_W'(36'h100 + n));
      applyStimulus(2, DATA_W'(36'h200 + n));
    end
    runBurst(2, 1'b0, '0, 1'b1, 1'b0);
    runBurst(1, 1'b0, '0, 1'b0, 1'b0);
    runBurst(2, 1'b0, '0, 1'b0, 1'b0);

    // Write coincident with rd_start becomes tap 0.
    runBurst(0, 1'b1, DATA_W'(36'hABC), 1'b0, 1'b0);

    // Out-of-range channel: write reports ready but is dropped, read ignored.
    applyStimulus(3, randData());
    bus.rd_start = 1'b1;
    bus.rd_chan  = CH_W'(3);
    step();
    bus.rd_start = 1'b0;
    checkOutput("badch_rd_busy", bus.rd_busy, 0);
    step();
    checkOutput("badch_q_valid", bus.q_valid, 0);
    runBurst(0, 1'b0, '0, 1'b0, 1'b0);

    // Reset in the middle of a burst.
    bus.rd_start = 1'b1;
    bus.rd_chan  = '0;
    step();
    bus.rd_start = 1'b0;
    repeat (7) step();
    checkOutput("midrst_q_valid_pre", bus.q_valid, 1);
    checkOutput("midrst_q_pre", bus.q, expTap(0, 6));
    reset = 1'b1;
    #1;
    checkOutput("midrst_rd_busy", bus.rd_busy, 0);
    checkOutput("midrst_q_valid", bus.q_valid, 0);
    checkOutput("midrst_q_last", bus.q_last, 0);
    checkOutput("midrst_q", bus.q, 0);
    checkOutput("midrst_q_chan", bus.q_chan, 0);
    checkOutput("midrst_wr_ready", bus.wr_ready, 1);
    for (int i = 0; i < CHANNELS; i++) hist[i].delete();
    step();
    step();
    reset = 1'b0;
    step();
    runBurst(0, 1'b0, '0, 1'b0, 1'b0);
    runBurst(2, 1'b0, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
